// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: round-robin arbiter that moves whole packets from NUM_PORTS
// upstream FIFOs (registered reads) to a single valid/ready downstream port.
//
// Ports:
//   clk, rst_n      single clock, synchronous active-low reset
//   port_empty      per-port FIFO empty flags
//   port_rd_en      per-port FIFO read strobe (one-hot, only in ISSUE)
//   port_rd_data    concatenated FIFO read data, port i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   port_mask       per-port arbitration enable
//   out_valid/out_ready/out_data/out_port_id   downstream packet interface
//   busy            high whenever the FSM is not idle
//   pkt_count       saturating count of delivered packets
module packet_rr_arbiter #(
    parameter int unsigned PACKET_WIDTH = 128,
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned PORT_ID_W    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              port_empty,
    output logic [NUM_PORTS-1:0]              port_rd_en,
    input  logic [NUM_PORTS*PACKET_WIDTH-1:0] port_rd_data,
    input  logic [NUM_PORTS-1:0]              port_mask,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PACKET_WIDTH-1:0]           out_data,
    output logic [PORT_ID_W-1:0]              out_port_id,
    output logic                              busy,
    output logic [15:0]                       pkt_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StSend} state_e;

    state_e                  state_q, state_d;
    logic [PORT_ID_W-1:0]    grant_q, grant_d;
    logic [PORT_ID_W-1:0]    last_grant_q, last_grant_d;
    logic [PACKET_WIDTH-1:0] out_data_q, out_data_d;
    logic [PORT_ID_W-1:0]    out_port_id_q, out_port_id_d;
    logic [15:0]             pkt_count_q, pkt_count_d;

    logic [NUM_PORTS-1:0]    req;
    logic [PORT_ID_W-1:0]    rr_grant;
    logic [PACKET_WIDTH-1:0] sel_data;

    // First requester at or above last+1, wrapping past the top port.
    function automatic logic [PORT_ID_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                                     input logic [PORT_ID_W-1:0] last);
        int   idx;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            idx = int'(last) + 1 + i;
            if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
            if (!found && r[PORT_ID_W'(idx)]) begin
                found   = 1'b1;
                rr_pick = PORT_ID_W'(idx);
            end
        end
    endfunction

    assign req      = ~port_empty & port_mask;
    assign rr_grant = rr_pick(req, last_grant_q);

    // Data mux for the granted port's slice.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant_q == PORT_ID_W'(i)) sel_data = port_rd_data[i*PACKET_WIDTH +: PACKET_WIDTH];
        end
    end

    always_comb begin
        port_rd_en = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            port_rd_en[i] = (state_q == StIssue) && (grant_q == PORT_ID_W'(i));
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        out_data_d    = out_data_q;
        out_port_id_d = out_port_id_q;
        pkt_count_d   = pkt_count_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    grant_d = rr_grant;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                last_grant_d = grant_q;
                state_d      = StWait;
            end
            StWait: begin
                // FIFO data for the ISSUE-cycle read is valid now.
                out_data_d    = sel_data;
                out_port_id_d = grant_q;
                state_d       = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            last_grant_q  <= PORT_ID_W'(NUM_PORTS - 1);
            out_data_q    <= '0;
            out_port_id_q <= '0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            out_data_q    <= out_data_d;
            out_port_id_q <= out_port_id_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    assign out_valid   = (state_q == StSend);
    assign busy        = (state_q != StIdle);
    assign out_data    = out_data_q;
    assign out_port_id = out_port_id_q;
    assign pkt_count   = pkt_count_q;

endmodule
